dma_rd_arb: RTL

DMA_RD_ARB -- requirements
Module: dma_rd_arb

---
 rtl/dma_rd_arb_pkg.sv | 26 ++
 rtl/rr_arb.sv | 32 +++
 rtl/dma_rd_arb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dma_rd_arb_pkg.sv
// Shared widths, client IDs and FSM encoding for the DMA read-channel arbiter.
package dma_rd_arb_pkg;

  localparam int DDR_AXI_ADDR_WIDTH  = 32;
  localparam int DDR_LEN_WIDTH       = 20;
  localparam int DDR_AXIS_DATA_WIDTH = 64;

  localparam int CLI_IM = 0;
  localparam int CLI_WM = 1;
  localparam int CLI_XM = 2;

  localparam int ERR_OVERRUN = 0;
  localparam int ERR_ORPHAN  = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_STREAM
  } arb_state_e;

  // Width of a client index; a single client still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin pick: the pending client nearest after last_grant.
module rr_arb
  import dma_rd_arb_pkg::*;
#(
  parameter int N_CLI = 3
) (
  input  logic [N_CLI-1:0]            pending,
  input  logic [idx_width(N_CLI)-1:0] last_grant,
  output logic                        gnt_valid,
  output logic [idx_width(N_CLI)-1:0] gnt_idx
);

  localparam int IW = idx_width(N_CLI);

  int best;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    best      = N_CLI;
    for (int j = 0; j < N_CLI; j++) begin
      // distance 0 is the client right after last_grant
      if (pending[j] && ((j + N_CLI - 1 - int'(last_grant)) % N_CLI) < best) begin
        best      = (j + N_CLI - 1 - int'(last_grant)) % N_CLI;
        gnt_valid = 1'b1;
        gnt_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dma_rd_arb.sv
// Shares one DMA read channel among N_CLI clients: per-client request slots,
// round-robin grant, descriptor issue and registered fan-out of the data stream.
module dma_rd_arb
  import dma_rd_arb_pkg::*;
#(
  parameter int N_CLI = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_CLI-1:0]                    req_valid,
  input  logic [N_CLI*DDR_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [N_CLI*DDR_LEN_WIDTH-1:0]      req_len,
  output logic [N_CLI-1:0]                    req_busy,
  output logic [DDR_AXI_ADDR_WIDTH-1:0]       dma_rd_desc_addr,
  output logic [DDR_LEN_WIDTH-1:0]            dma_rd_desc_len,
  output logic                                dma_rd_desc_valid,
  input  logic                                dma_rd_desc_ready,
  input  logic [DDR_AXIS_DATA_WIDTH-1:0]      dma_rd_read_data_tdata,
  input  logic                                dma_rd_read_data_tvalid,
  input  logic                                dma_rd_read_data_tlast,
  output logic [DDR_AXIS_DATA_WIDTH-1:0]      cli_tdata,
  output logic                                cli_tlast,
  output logic [N_CLI-1:0]                    cli_tvalid,
  output logic [idx_width(N_CLI)-1:0]         grant_id,
  output logic [1:0]                          err
);

  localparam int IW = idx_width(N_CLI);
  localparam int AW = DDR_AXI_ADDR_WIDTH;
  localparam int LW = DDR_LEN_WIDTH;

  arb_state_e     state;
  logic [N_CLI-1:0] pending;
  logic [N_CLI-1:0] take;
  logic [N_CLI-1:0] accept;
  logic           overrun;
  logic [IW-1:0]  last_grant;
  logic           gnt_valid;
  logic [IW-1:0]  gnt_idx;

  logic [AW-1:0]  slot_addr [N_CLI];
  logic [LW-1:0]  slot_len  [N_CLI];

  rr_arb #(.N_CLI(N_CLI)) u_rr_arb (
    .pending    (pending),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // A slot being granted this cycle is free again, so a same-cycle pulse refills it.
  assign take     = (state == ST_IDLE && gnt_valid) ? (N_CLI'(1) << gnt_idx) : '0;
  assign accept   = req_valid & ~(pending & ~take);
  assign overrun  = |(req_valid & pending & ~take);
  assign req_busy = pending | ((state != ST_IDLE) ? (N_CLI'(1) << grant_id) : '0);

  // NOTE: slot storage has no reset; a slot is only read while its pending bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CLI; i++) begin
      if (accept[i]) begin
        slot_addr[i] <= req_addr[i*AW +: AW];
        slot_len[i]  <= req_len[i*LW +: LW];
      end
    end
  end

  // NOTE: all state updates use non-blocking assignments so each register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      pending           <= '0;
      last_grant        <= IW'(N_CLI - 1);
      grant_id          <= '0;
      dma_rd_desc_valid <= 1'b0;
      dma_rd_desc_addr  <= '0;
      dma_rd_desc_len   <= '0;
      cli_tvalid        <= '0;
      cli_tdata         <= '0;
      cli_tlast         <= 1'b0;
      err               <= '0;
    end else begin
      pending    <= (pending & ~take) | accept;
      cli_tvalid <= '0;
      if (overrun) err[ERR_OVERRUN] <= 1'b1;
      if (dma_rd_read_data_tvalid && state != ST_STREAM) err[ERR_ORPHAN] <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            last_grant <= gnt_idx;
            // zero-length requests are consumed here and never reach the DMA
            if (|slot_len[gnt_idx]) begin
              grant_id          <= gnt_idx;
              dma_rd_desc_addr  <= slot_addr[gnt_idx];
              dma_rd_desc_len   <= slot_len[gnt_idx];
              dma_rd_desc_valid <= 1'b1;
              state             <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (dma_rd_desc_ready) begin
            dma_rd_desc_valid <= 1'b0;
            state             <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (dma_rd_read_data_tvalid) begin
            cli_tdata  <= dma_rd_read_data_tdata;
            cli_tlast  <= dma_rd_read_data_tlast;
            cli_tvalid <= N_CLI'(1) << grant_id;
            if (dma_rd_read_data_tlast) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
